// File: rtl/stream_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_rx_pkg
// Description : Shared constants and helpers for the stream receive buffer.
//               Default geometry, pointer-width helper and the width of the
//               optional dropped-word counter (STREAM_RX_OVF_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package stream_rx_pkg;

    localparam int DEF_WIDTH     = 10;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_THRESH = 12;
    localparam int OVF_CNT_W     = 16;

    // Number of bits needed to address 'depth' entries.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : stream_rx_pkg
`default_nettype wire

// File: rtl/stream_rx_mem.sv
`default_nettype none
// ============================================================================
// Module      : stream_rx_mem
// Description : Register-array dual-port memory. One synchronous write port,
//               one asynchronous (combinational) read port. Contents are not
//               reset.
// Ports       : clk_i            clock
//               we_i             write enable
//               waddr_i/wdata_i  write address / data
//               raddr_i          read address
//               rdata_o          read data (combinational from the array)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_rx_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : stream_rx_mem
`default_nettype wire

// File: rtl/stream_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stream_rx_buffer
// Description : Circular buffer behind a no-backpressure DIN/DIN_DV stream.
//               Re-issues words first-word-fall-through over DOUT/DOUT_DV/
//               DOUT_RDY, reports fill level, almost-full and a sticky
//               overflow flag for words that arrived while full.
// Ports       : CLK, RST          clock, synchronous active-high reset
//               DIN, DIN_DV       input stream (must be taken or is lost)
//               DOUT, DOUT_DV     head of buffer and its valid
//               DOUT_RDY          downstream ready
//               LEVEL             words held, 0..DEPTH
//               ALMOST_FULL       LEVEL >= AF_THRESH
//               OVERFLOW, OVF_CLR sticky drop flag and its clear
//               OVF_CNT           dropped-word count (only with
//                                 STREAM_RX_OVF_CNT_EN defined)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_rx_buffer
    import stream_rx_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [WIDTH-1:0]                DIN,
    input  logic                            DIN_DV,
    output logic [WIDTH-1:0]                DOUT,
    output logic                            DOUT_DV,
    input  logic                            DOUT_RDY,
    output logic [$clog2(DEPTH):0]          LEVEL,
    output logic                            ALMOST_FULL,
    output logic                            OVERFLOW,
    input  logic                            OVF_CLR
`ifdef STREAM_RX_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0]            OVF_CNT
`endif
);

    localparam int            AW      = ptr_width(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [AW-1:0] C_PINC  = AW'(1);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full = (count_q == C_DEPTH);
    assign w_pop  = (count_q != '0) && DOUT_RDY;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign w_push = DIN_DV && (!w_full || w_pop);
    assign w_drop = DIN_DV && w_full && !w_pop;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + C_ONE;
        end else if (w_pop && !w_push) begin
            count_d = count_q - C_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + C_PINC;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + C_PINC;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                ovf_q <= 1'b1;
            end else if (OVF_CLR) begin
                ovf_q <= 1'b0;
            end
        end
    end

    stream_rx_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (w_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (DIN),
        .raddr_i (rd_ptr_q),
        .rdata_o (DOUT)
    );

    assign DOUT_DV     = (count_q != '0);
    assign LEVEL       = count_q;
    assign ALMOST_FULL = (count_q >= C_AF);
    assign OVERFLOW    = ovf_q;

`ifdef STREAM_RX_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_cnt_q <= '0;
        end else if (w_drop) begin
            // Clear plus drop leaves exactly the one new drop counted.
            if (OVF_CLR) begin
                ovf_cnt_q <= OVF_CNT_W'(1);
            end else if (ovf_cnt_q != '1) begin
                ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
            end
        end else if (OVF_CLR) begin
            ovf_cnt_q <= '0;
        end
    end

    assign OVF_CNT = ovf_cnt_q;
`endif

endmodule : stream_rx_buffer
`default_nettype wire

// File: tb/tb_stream_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_rx_buffer
// Description : Self-checking bench for stream_rx_buffer (default geometry
//               WIDTH=10, DEPTH=16, AF_THRESH=12). Vector table, directed
//               corner sequences and a queue-based reference model under
//               random stimulus. Honours STREAM_RX_OVF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_rx_buffer;

    localparam int WIDTH = 10;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [WIDTH-1:0] DIN = '0;
    logic             DIN_DV = 1'b0;
    logic             DOUT_RDY = 1'b0;
    logic             OVF_CLR = 1'b0;
    logic [WIDTH-1:0] DOUT;
    logic             DOUT_DV;
    logic [4:0]       LEVEL;
    logic             ALMOST_FULL;
    logic             OVERFLOW;
`ifdef STREAM_RX_OVF_CNT_EN
    logic [15:0]      OVF_CNT;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    stream_rx_buffer #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AFT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .DIN         (DIN),
        .DIN_DV      (DIN_DV),
        .DOUT        (DOUT),
        .DOUT_DV     (DOUT_DV),
        .DOUT_RDY    (DOUT_RDY),
        .LEVEL       (LEVEL),
        .ALMOST_FULL (ALMOST_FULL),
        .OVERFLOW    (OVERFLOW),
        .OVF_CLR     (OVF_CLR)
`ifdef STREAM_RX_OVF_CNT_EN
        ,
        .OVF_CNT     (OVF_CNT)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rst, input logic dv, input int din,
                         input logic rdy, input logic clr);
        RST      = rst;
        DIN_DV   = dv;
        DIN      = WIDTH'(din);
        DOUT_RDY = rdy;
        OVF_CLR  = clr;
    endtask

    typedef struct {
        logic rst;
        logic dv;
        int   din;
        logic rdy;
        logic clr;
        logic e_dv;
        int   e_dout;
        int   e_level;
        logic e_af;
        logic e_ovf;
    } vec_t;

    // Reference model state: contents as a plain queue, plus flags.
    int   mq[$];
    logic m_ovf;
    int   m_cnt;

    task automatic model_step(input logic rst, input logic dv, input int din,
                              input logic rdy, input logic clr);
        bit pop, was_full;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            pop      = (mq.size() > 0) && rdy;
            if (pop) void'(mq.pop_front());
            if (dv && (!was_full || pop)) begin
                mq.push_back(din);
                if (clr) begin m_ovf = 1'b0; m_cnt = 0; end
            end else if (dv) begin
                m_ovf = 1'b1;
                m_cnt = clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
            end else if (clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic model_compare(input string tag);
        chk({tag, ".dv"}, int'(DOUT_DV), int'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".dout"}, int'(DOUT), mq[0]);
        chk({tag, ".level"}, int'(LEVEL), mq.size());
        chk({tag, ".af"}, int'(ALMOST_FULL), int'(mq.size() >= AFT));
        chk({tag, ".ovf"}, int'(OVERFLOW), int'(m_ovf));
`ifdef STREAM_RX_OVF_CNT_EN
        chk({tag, ".ovfcnt"}, int'(OVF_CNT), m_cnt);
`endif
    endtask

    initial begin
        vec_t vt[10];
        int   p_dv, p_rdy;

        #1;
        // ---------------- table-driven vectors ----------------
        //           rst dv din rdy clr | e_dv dout lvl af ovf
        vt[0] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b1, 5, 1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b1, 7, 1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b1, 7, 2, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 9, 1'b1, 1'b0, 1'b1, 8, 2, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 9, 1, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1, 3, 1, 1'b0, 1'b0};
        vt[8] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        vt[9] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].rst, vt[i].dv, vt[i].din, vt[i].rdy, vt[i].clr);
            tick();
            chk($sformatf("vec%0d.dv", i), int'(DOUT_DV), int'(vt[i].e_dv));
            if (vt[i].e_dv) chk($sformatf("vec%0d.dout", i), int'(DOUT), vt[i].e_dout);
            chk($sformatf("vec%0d.level", i), int'(LEVEL), vt[i].e_level);
            chk($sformatf("vec%0d.af", i), int'(ALMOST_FULL), int'(vt[i].e_af));
            chk($sformatf("vec%0d.ovf", i), int'(OVERFLOW), int'(vt[i].e_ovf));
        end

        // ---------------- burst 1..59 with ready held ----------------
        for (int i = 1; i <= 59; i++) begin
            drive(1'b0, 1'b1, i, 1'b1, 1'b0);
            tick();
            chk("burst.dv", int'(DOUT_DV), 1);
            chk("burst.dout", int'(DOUT), i);
            chk("burst.level", int'(LEVEL), 1);
            chk("burst.ovf", int'(OVERFLOW), 0);
        end
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("burst.end_level", int'(LEVEL), 0);

        // ---------------- fill, almost-full, drop ----------------
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, i, 1'b0, 1'b0);
            tick();
            chk("fill.level", int'(LEVEL), i);
            chk("fill.af", int'(ALMOST_FULL), int'(i >= AFT));
            chk("fill.head", int'(DOUT), 1);
        end
        drive(1'b0, 1'b1, 17, 1'b0, 1'b0);
        tick();
        chk("drop.level", int'(LEVEL), 16);
        chk("drop.ovf", int'(OVERFLOW), 1);
        chk("drop.head", int'(DOUT), 1);
`ifdef STREAM_RX_OVF_CNT_EN
        chk("drop.ovfcnt", int'(OVF_CNT), 1);
`endif
        // Push while full with a coincident pop: accepted, no drop.
        drive(1'b0, 1'b1, 99, 1'b1, 1'b0);
        tick();
        chk("fullpp.level", int'(LEVEL), 16);
        chk("fullpp.head", int'(DOUT), 2);
`ifdef STREAM_RX_OVF_CNT_EN
        chk("fullpp.ovfcnt", int'(OVF_CNT), 1);
`endif
        // Drain: 2..16 then 99; 17 must never appear.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
            chk("drain.dv", int'(DOUT_DV), 1);
            chk("drain.dout", int'(DOUT), (i < 15) ? i + 2 : 99);
            tick();
        end
        chk("drain.empty_dv", int'(DOUT_DV), 0);
        chk("drain.empty_level", int'(LEVEL), 0);

        // ---------------- overflow clear ----------------
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        chk("clr.ovf", int'(OVERFLOW), 0);
`ifdef STREAM_RX_OVF_CNT_EN
        chk("clr.ovfcnt", int'(OVF_CNT), 0);
`endif
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, 100 + i, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 500, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 501, 1'b0, 1'b1);
        tick();
        chk("clrdrop.ovf", int'(OVERFLOW), 1);
        chk("clrdrop.level", int'(LEVEL), 16);
`ifdef STREAM_RX_OVF_CNT_EN
        chk("clrdrop.ovfcnt", int'(OVF_CNT), 1);
`endif

        // ---------------- reset mid-drain ----------------
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
            tick();
        end
        chk("middrain.level", int'(LEVEL), 7);
        chk("middrain.head", int'(DOUT), 110);
        drive(1'b1, 1'b1, 55, 1'b1, 1'b0);
        tick();
        chk("rst.dv", int'(DOUT_DV), 0);
        chk("rst.level", int'(LEVEL), 0);
        chk("rst.ovf", int'(OVERFLOW), 0);
        chk("rst.af", int'(ALMOST_FULL), 0);
        drive(1'b0, 1'b1, 42, 1'b0, 1'b0);
        tick();
        chk("after_rst.dv", int'(DOUT_DV), 1);
        chk("after_rst.dout", int'(DOUT), 42);
        chk("after_rst.level", int'(LEVEL), 1);

        // ---------------- random vs reference model ----------------
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        model_compare("rnd_rst");
        p_dv  = 70;
        p_rdy = 50;
        for (int c = 0; c < 3000; c++) begin
            logic r_rst, r_dv, r_rdy, r_clr;
            int   r_din;
            if ((c % 150) == 0) begin
                p_dv  = $urandom_range(30, 95);
                p_rdy = $urandom_range(5, 95);
            end
            r_rst = ($urandom_range(0, 299) == 0);
            r_dv  = ($urandom_range(0, 99) < p_dv);
            r_rdy = ($urandom_range(0, 99) < p_rdy);
            r_clr = ($urandom_range(0, 19) == 0);
            r_din = $urandom_range(0, (1 << WIDTH) - 1);
            drive(r_rst, r_dv, r_din, r_rdy, r_clr);
            model_step(r_rst, r_dv, r_din, r_rdy, r_clr);
            tick();
            model_compare("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stream_rx_buffer
`default_nettype wire
